// File: rtl/set_scan_ctrl_pkg.sv
// Shared widths, field layout, mode/state encodings and the mode match decode
// for the grid-sweep controller and its coverage PE.
package set_scan_ctrl_pkg;

  localparam int AXIS_W     = 4;             // one coordinate axis
  localparam int COORD_SZ   = 2 * AXIS_W;    // {x,y}
  localparam int NUM_CIRC   = 3;             // A, B, C
  localparam int CENTRAL_SZ = NUM_CIRC * COORD_SZ;  // {A_X,A_Y,B_X,B_Y,C_X,C_Y}
  localparam int RADIUS_SZ  = NUM_CIRC * AXIS_W;    // {A_R,B_R,C_R}
  localparam int COVERED_SZ = NUM_CIRC;             // [2]=A,[1]=B,[0]=C

  typedef enum logic [1:0] {
    MODE_A   = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2,
    MODE_TWO = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Does this point's coverage pattern satisfy the job mode?
  function automatic logic match(input logic [COVERED_SZ-1:0] cov, input mode_e mode);
    logic m;
    m = 1'b0;
    case (mode)
      MODE_A:   m = cov[2];
      MODE_AND: m = cov[2] & cov[1];
      MODE_XOR: m = cov[2] ^ cov[1];
      MODE_TWO: m = (cov == 3'b110) || (cov == 3'b101) || (cov == 3'b011);
      default:  m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/set_scan_ctrl_if.sv
// Job interface: host drives a request plus circle data, controller returns
// busy, a one-cycle valid and the matching-point count.
interface set_scan_ctrl_if import set_scan_ctrl_pkg::*; #(
  parameter int CNT_W = 7
) ();
  logic                  en;
  logic [CENTRAL_SZ-1:0] central;
  logic [RADIUS_SZ-1:0]  radius;
  logic [1:0]            mode;
  logic                  busy;
  logic                  valid;
  logic [CNT_W-1:0]      candidate;

  modport master (output en, central, radius, mode, input busy, valid, candidate);
  modport slave  (input en, central, radius, mode, output busy, valid, candidate);
endinterface

// File: rtl/set_scan_ctrl_pe.sv
// Circle-coverage PE: for one grid point, flags each circle whose closed disc
// contains it (a point exactly on the edge counts as covered).
module set_scan_ctrl_pe import set_scan_ctrl_pkg::*; (
  input  logic [COORD_SZ-1:0]   coord,
  input  logic [CENTRAL_SZ-1:0] central,
  input  logic [RADIUS_SZ-1:0]  radius,
  output logic [COVERED_SZ-1:0] covered
);
  logic [AXIS_W-1:0] px, py;
  assign px = coord[COORD_SZ-1 -: AXIS_W];
  assign py = coord[AXIS_W-1 -: AXIS_W];

  // Circle i sits at field i counted from the LSB, so covered[i] lines up with it.
  for (genvar i = 0; i < NUM_CIRC; i++) begin : g_circ
    logic [AXIS_W-1:0] cx, cy, r, adx, ady;
    logic [7:0]        sx, sy, r2;
    logic [8:0]        d2;
    assign cx  = central[i*COORD_SZ + COORD_SZ-1 -: AXIS_W];
    assign cy  = central[i*COORD_SZ + AXIS_W-1 -: AXIS_W];
    assign r   = radius[i*AXIS_W + AXIS_W-1 -: AXIS_W];
    // Unsigned distance per axis avoids signed arithmetic entirely.
    assign adx = (px >= cx) ? px - cx : cx - px;
    assign ady = (py >= cy) ? py - cy : cy - py;
    assign sx  = 8'(adx) * 8'(adx);
    assign sy  = 8'(ady) * 8'(ady);
    assign r2  = 8'(r) * 8'(r);
    assign d2  = 9'(sx) + 9'(sy);
    assign covered[i] = (d2 <= 9'(r2));
  end
endmodule

// File: rtl/set_scan_ctrl.sv
// Grid-sweep controller: latches one job, walks every point of the
// (1..GRID_MAX)^2 grid through the PE one per cycle, counts matches and
// returns the count with a single-cycle valid.
module set_scan_ctrl import set_scan_ctrl_pkg::*; #(
  parameter int GRID_MAX = 8,
  parameter int CNT_W    = 7
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  set_scan_ctrl_if.slave   job
);
  localparam logic [AXIS_W-1:0] LAST = AXIS_W'(GRID_MAX);

  state_e                state;
  logic [AXIS_W-1:0]     x, y;
  logic [CNT_W-1:0]      cnt;
  logic [CENTRAL_SZ-1:0] central_buf;
  logic [RADIUS_SZ-1:0]  radius_buf;
  mode_e                 mode_buf;
  logic                  busy_q, valid_q;
  logic [CNT_W-1:0]      cand_q;
  logic [COVERED_SZ-1:0] covered;
  logic                  hit;

  set_scan_ctrl_pe u_pe (
    .coord   ({x, y}),
    .central (central_buf),
    .radius  (radius_buf),
    .covered (covered)
  );

  assign hit = match(covered, mode_buf);

  assign job.busy      = busy_q;
  assign job.valid     = valid_q;
  assign job.candidate = cand_q;

  // Job FSM: IDLE accepts a job, SCAN sweeps x inner / y outer, DONE pulses valid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      x           <= AXIS_W'(1);
      y           <= AXIS_W'(1);
      cnt         <= '0;
      central_buf <= '0;
      radius_buf  <= '0;
      mode_buf    <= MODE_A;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      cand_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Inputs are only looked at here, so mid-job changes never leak in.
          if (job.en) begin
            central_buf <= job.central;
            radius_buf  <= job.radius;
            mode_buf    <= mode_e'(job.mode);
            cnt         <= '0;
            x           <= AXIS_W'(1);
            y           <= AXIS_W'(1);
            busy_q      <= 1'b1;
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          cnt <= cnt + CNT_W'(hit);
          if (x == LAST) begin
            x <= AXIS_W'(1);
            if (y == LAST) begin
              // Last point: fold its hit straight into the result.
              y       <= AXIS_W'(1);
              cand_q  <= cnt + CNT_W'(hit);
              valid_q <= 1'b1;
              state   <= ST_DONE;
            end else begin
              y <= y + AXIS_W'(1);
            end
          end else begin
            x <= x + AXIS_W'(1);
          end
        end
        ST_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_set_scan_ctrl.sv
// Bench for set_scan_ctrl: directed jobs, mid-job request, mid-job reset and
// random jobs checked against a plain-arithmetic coverage model.
module tb_set_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  set_scan_ctrl_if #(.CNT_W(7)) job();

  set_scan_ctrl #(.GRID_MAX(8), .CNT_W(7)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .job     (job)
  );

  int n_cmp = 0;
  int n_err = 0;
  int prev_cand = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Count grid points whose circle membership satisfies the mode.
  function automatic int ref_count(input logic [23:0] cen, input logic [11:0] rad, input int mode);
    int n, cx, cy, r, nin;
    bit in_c [3];
    bit m;
    n = 0;
    for (int px = 1; px <= 8; px++) begin
      for (int py = 1; py <= 8; py++) begin
        for (int k = 0; k < 3; k++) begin  // k=0:A 1:B 2:C
          cx = int'(cen >> (20 - 8*k)) & 15;
          cy = int'(cen >> (16 - 8*k)) & 15;
          r  = int'(rad >> (8 - 4*k)) & 15;
          in_c[k] = ((px-cx)*(px-cx) + (py-cy)*(py-cy)) <= r*r;
        end
        nin = int'(in_c[0]) + int'(in_c[1]) + int'(in_c[2]);
        case (mode)
          0:       m = in_c[0];
          1:       m = in_c[0] && in_c[1];
          2:       m = in_c[0] != in_c[1];
          default: m = (nin == 2);
        endcase
        if (m) n++;
      end
    end
    return n;
  endfunction

  // Issue one job; exp_in < 0 means take the expectation from the model.
  task automatic run_job(input string tag, input logic [23:0] cen, input logic [11:0] rad,
                         input logic [1:0] mode, input bit inject, input int exp_in);
    int exp, cyc, drops;
    bit seen;
    exp = (exp_in < 0) ? ref_count(cen, rad, int'(mode)) : exp_in;
    job.central = cen;
    job.radius  = rad;
    job.mode    = mode;
    job.en      = 1'b1;
    @(posedge clk); #1;
    job.en      = 1'b0;
    job.central = 24'($urandom);
    job.radius  = 12'($urandom);
    job.mode    = 2'($urandom);
    cyc = 0; drops = 0; seen = 1'b0;
    if (job.busy !== 1'b1) drops++;
    while (cyc < 100 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (job.busy !== 1'b1) drops++;
      if (cyc == 5) chk({tag, " cand_hold"}, int'(job.candidate), prev_cand);
      if (inject && cyc == 10) begin
        job.en      = 1'b1;
        job.central = 24'($urandom);
        job.radius  = 12'($urandom);
        job.mode    = 2'($urandom);
      end
      if (inject && cyc == 11) job.en = 1'b0;
      if (job.valid === 1'b1) seen = 1'b1;
    end
    job.en = 1'b0;
    chk({tag, " valid_seen"}, int'(seen), 1);
    chk({tag, " latency"}, cyc, 64);
    chk({tag, " count"}, int'(job.candidate), exp);
    chk({tag, " busy_hold"}, drops, 0);
    @(posedge clk); #1;
    chk({tag, " valid_1cyc"}, int'(job.valid), 0);
    chk({tag, " busy_clr"}, int'(job.busy), 0);
    chk({tag, " cand_keep"}, int'(job.candidate), exp);
    prev_cand = exp;
  endtask

  initial begin
    int nvalid;
    logic [23:0] rc;
    logic [11:0] rr;
    job.en = 1'b0; job.central = '0; job.radius = '0; job.mode = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", int'(job.busy), 0);
    chk("rst valid", int'(job.valid), 0);
    chk("rst cand", int'(job.candidate), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle busy", int'(job.busy), 0);

    run_job("t1", {4'd4,4'd4,4'd8,4'd8,4'd8,4'd8}, {4'd0,4'd0,4'd0}, 2'd0, 1'b0, 1);
    run_job("t2a", {4'd1,4'd1,4'd8,4'd8,4'd8,4'd8}, {4'd15,4'd0,4'd0}, 2'd0, 1'b0, 64);
    run_job("t2b", {4'd1,4'd1,4'd8,4'd8,4'd8,4'd8}, {4'd0,4'd0,4'd0}, 2'd1, 1'b0, 0);
    run_job("t3", {4'd4,4'd4,4'd5,4'd4,4'd8,4'd8}, {4'd1,4'd1,4'd0}, 2'd2, 1'b0, 6);
    run_job("t4a", {4'd4,4'd4,4'd5,4'd4,4'd8,4'd8}, {4'd1,4'd1,4'd0}, 2'd3, 1'b0, 2);
    run_job("t4b", {4'd4,4'd4,4'd5,4'd4,4'd4,4'd4}, {4'd1,4'd1,4'd0}, 2'd3, 1'b0, 1);
    // Idle gap: result must persist.
    repeat (5) @(posedge clk);
    #1;
    chk("idle cand_keep", int'(job.candidate), prev_cand);
    run_job("t5", {4'd4,4'd4,4'd8,4'd8,4'd8,4'd8}, {4'd0,4'd0,4'd0}, 2'd0, 1'b1, 1);

    // Reset 30 cycles into a scan.
    job.central = {4'd1,4'd1,4'd8,4'd8,4'd8,4'd8};
    job.radius  = {4'd15,4'd0,4'd0};
    job.mode    = 2'd0;
    job.en      = 1'b1;
    @(posedge clk); #1;
    job.en = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6 rst busy", int'(job.busy), 0);
    chk("t6 rst valid", int'(job.valid), 0);
    chk("t6 rst cand", int'(job.candidate), 0);
    prev_cand = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (job.valid !== 1'b0 || job.busy !== 1'b0) nvalid++;
    end
    chk("t6 no_stale", nvalid, 0);
    run_job("t6 fresh", {4'd4,4'd4,4'd5,4'd4,4'd8,4'd8}, {4'd1,4'd1,4'd0}, 2'd2, 1'b0, 6);

    // Random jobs, centres biased onto the grid so counts vary.
    for (int j = 0; j < 12; j++) begin
      for (int k = 0; k < 6; k++) rc[k*4 +: 4] = 4'($urandom_range(0, 10));
      rr = 12'($urandom);
      run_job($sformatf("rnd%0d", j), rc, rr, 2'($urandom), 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
